// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard sequencer.
// State encoding is fixed so it can be read directly off a probe.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  localparam int REG_ADDR_W  = 4;
  localparam int STALL_CNT_W = 16;

  function automatic logic reg_hit(input logic uses,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline status in, stage enables/flushes out.
// master = hazard controller, slave = pipeline datapath.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0]  id_rs_addr;
  logic [REG_ADDR_W-1:0]  id_rt_addr;
  logic                   id_uses_rs;
  logic                   id_uses_rt;
  logic                   id_halt;
  logic [REG_ADDR_W-1:0]  ex_rd_addr;
  logic                   ex_mem_read;
  logic                   ex_reg_write;
  logic                   ex_redirect;
  logic                   mem_req;
  logic                   mem_ready;
  logic                   resume;
  logic                   stat_clr;

  logic                   pc_wen;
  logic                   ifid_wen;
  logic                   ifid_flush;
  logic                   idex_wen;
  logic                   idex_flush;
  logic                   exmem_wen;
  logic                   memwb_flush;
  logic                   halted;
  logic                   mem_err;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_halt,
           ex_rd_addr, ex_mem_read, ex_reg_write, ex_redirect,
           mem_req, mem_ready, resume, stat_clr,
    output pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush,
           exmem_wen, memwb_flush, halted, mem_err, stall_count
  );

  modport slave (
    output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_halt,
           ex_rd_addr, ex_mem_read, ex_reg_write, ex_redirect,
           mem_req, mem_ready, resume, stat_clr,
    input  pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush,
           exmem_wen, memwb_flush, halted, mem_err, stall_count
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// One-cycle update latency, no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: stage enables/flushes for load-use, redirect, mem wait, halt.
// Controls are combinational from registered state (same-cycle effect); memory wait freezes IF..EX.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter bit          R0_HARDWIRED = 1'b1
) (
  input logic                clk,
  input logic                rst,
  pipe_hazard_ctrl_if.master bus
);

  localparam int TMO_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int DRN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  localparam logic [TMO_W:0]   TMO_LAST = (TMO_W + 1)'(MEM_TIMEOUT);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  state_e             state_q, state_d;
  state_e             ret_q, ret_d;
  state_e             eff_state;
  logic               mem_err_q, mem_err_d;
  logic [DRN_W-1:0]   dcnt_q, dcnt_d;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [TMO_W:0]     tmo_next;
  logic [STALL_CNT_W-1:0] stall_cnt;

  logic mem_wait, load_use, r0_block;
  logic pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, memwb_flush;

  assign mem_wait = bus.mem_req && !bus.mem_ready && (state_q != ST_HALTED);
  assign r0_block = R0_HARDWIRED && (bus.ex_rd_addr == '0);
  assign load_use = bus.ex_mem_read && bus.ex_reg_write && !r0_block &&
                    (reg_hit(bus.id_uses_rs, bus.id_rs_addr, bus.ex_rd_addr) ||
                     reg_hit(bus.id_uses_rt, bus.id_rt_addr, bus.ex_rd_addr));

  // The mem_ready cycle is handled as if already back in the interrupted state.
  assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
  assign tmo_next  = {1'b0, tmo_cnt} + (TMO_W + 1)'(1);

  always_comb begin
    pc_wen      = 1'b1;
    ifid_wen    = 1'b1;
    ifid_flush  = 1'b0;
    idex_wen    = 1'b1;
    idex_flush  = 1'b0;
    exmem_wen   = 1'b1;
    memwb_flush = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    dcnt_d      = dcnt_q;
    mem_err_d   = mem_err_q;

    if (state_q == ST_HALTED) begin
      pc_wen    = 1'b0;
      ifid_wen  = 1'b0;
      idex_wen  = 1'b0;
      exmem_wen = 1'b0;
      if (bus.resume && !mem_err_q) begin
        pc_wen     = 1'b1;
        ifid_flush = 1'b1;
        state_d    = ST_RUN;
      end
    end else if (mem_wait) begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_wen    = 1'b0;
      exmem_wen   = 1'b0;
      memwb_flush = 1'b1;
      if (state_q != ST_MEM_WAIT) ret_d = state_q;
      state_d = ST_MEM_WAIT;
      if ((MEM_TIMEOUT != 0) && (tmo_next == TMO_LAST)) begin
        mem_err_d = 1'b1;
        state_d   = ST_HALTED;
        dcnt_d    = '0;
      end
    end else if (bus.ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = ST_RUN;
      dcnt_d     = '0;
    end else begin
      state_d = eff_state;
      if (load_use) begin
        pc_wen     = 1'b0;
        ifid_wen   = 1'b0;
        idex_flush = 1'b1;
      end
      // The halt is held in IF/ID from the detect cycle through the whole drain.
      if (eff_state == ST_DRAIN) begin
        pc_wen     = 1'b0;
        ifid_wen   = 1'b0;
        idex_flush = 1'b1;
        if (dcnt_q == DRN_LAST) begin
          state_d = ST_HALTED;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DRN_W'(1);
        end
      end else if (bus.id_halt && !load_use) begin
        pc_wen     = 1'b0;
        ifid_wen   = 1'b0;
        idex_flush = 1'b1;
        state_d    = ST_DRAIN;
        dcnt_d     = '0;
      end
    end

    if (!rst) begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_wen    = 1'b0;
      exmem_wen   = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      ret_q     <= ST_RUN;
      dcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      dcnt_q    <= dcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  sat_counter #(.W(TMO_W)) u_tmo_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (mem_wait),
    .clr_i (!mem_wait),
    .cnt_o (tmo_cnt)
  );

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (!pc_wen && (state_q != ST_HALTED)),
    .clr_i (bus.stat_clr),
    .cnt_o (stall_cnt)
  );

  assign bus.pc_wen      = pc_wen;
  assign bus.ifid_wen    = ifid_wen;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_wen    = idex_wen;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_wen   = exmem_wen;
  assign bus.memwb_flush = memwb_flush;
  assign bus.halted      = rst && (state_q == ST_HALTED);
  assign bus.mem_err     = rst && mem_err_q;
  assign bus.stall_count = rst ? stall_cnt : '0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; control word = {pc,ifid_wen,ifid_flush,idex_wen,idex_flush,exmem,memwb_flush}.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  localparam logic [6:0] C_NORM   = 7'b1101010;
  localparam logic [6:0] C_RST    = 7'b0010101;
  localparam logic [6:0] C_STALL  = 7'b0001110;
  localparam logic [6:0] C_REDIR  = 7'b1111110;
  localparam logic [6:0] C_MWAIT  = 7'b0000001;
  localparam logic [6:0] C_HALT   = 7'b0000000;
  localparam logic [6:0] C_RESUME = 7'b1010000;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT  (8),
    .DRAIN_CYCLES (3),
    .R0_HARDWIRED (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {bus.pc_wen, bus.ifid_wen, bus.ifid_flush, bus.idex_wen,
            bus.idex_flush, bus.exmem_wen, bus.memwb_flush};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs_addr = '0; bus.id_rt_addr = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.id_halt = 0; bus.ex_rd_addr = '0; bus.ex_mem_read = 0; bus.ex_reg_write = 0;
    bus.ex_redirect = 0; bus.mem_req = 0; bus.mem_ready = 0; bus.resume = 0; bus.stat_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    bus.ex_redirect = 1;
    rst = 0;
    #1;
    total++; if (ctl() !== C_RST) begin bad++; $display("FAIL rst_ctl got=%b exp=%b", ctl(), C_RST); end
    step();
    total++; if (bus.halted !== 1'b0 || bus.mem_err !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", bus.halted, bus.mem_err); end
    total++; if (bus.stall_count !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bus.stall_count); end
    rst = 1;
    idle();
    #1;
    total++; if (ctl() !== C_NORM) begin bad++; $display("FAIL run_default got=%b exp=%b", ctl(), C_NORM); end
  endtask

  task automatic test_load_use();
    bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_rd_addr = 4'd5;
    bus.id_rs_addr = 4'd5; bus.id_uses_rs = 1;
    #1;
    total++; if (ctl() !== C_STALL) begin bad++; $display("FAIL lu_rs got=%b exp=%b", ctl(), C_STALL); end
    step();
    idle();
    #1;
    total++; if (ctl() !== C_NORM) begin bad++; $display("FAIL lu_after got=%b exp=%b", ctl(), C_NORM); end
    total++; if (bus.stall_count !== 16'd1) begin bad++; $display("FAIL lu_cnt1 got=%0d exp=1", bus.stall_count); end
    // rt path match, rs present but different
    bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_rd_addr = 4'd9;
    bus.id_rs_addr = 4'd3; bus.id_uses_rs = 1; bus.id_rt_addr = 4'd9; bus.id_uses_rt = 1;
    #1;
    total++; if (ctl() !== C_STALL) begin bad++; $display("FAIL lu_rt got=%b exp=%b", ctl(), C_STALL); end
    step();
    bus.ex_rd_addr = 4'd0; bus.id_rs_addr = 4'd0; bus.id_rt_addr = 4'd0;
    #1;
    total++; if (ctl() !== C_NORM) begin bad++; $display("FAIL lu_r0 got=%b exp=%b", ctl(), C_NORM); end
    step();
    bus.ex_rd_addr = 4'd7; bus.id_rs_addr = 4'd7; bus.ex_reg_write = 0;
    #1;
    total++; if (ctl() !== C_NORM) begin bad++; $display("FAIL lu_nowr got=%b exp=%b", ctl(), C_NORM); end
    step();
    bus.ex_reg_write = 1; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    #1;
    total++; if (ctl() !== C_NORM) begin bad++; $display("FAIL lu_nouse got=%b exp=%b", ctl(), C_NORM); end
    step();
    idle();
    #1;
    total++; if (bus.stall_count !== 16'd2) begin bad++; $display("FAIL lu_cnt2 got=%0d exp=2", bus.stall_count); end
    bus.stat_clr = 1;
    step();
    bus.stat_clr = 0;
    #1;
    total++; if (bus.stall_count !== 16'd0) begin bad++; $display("FAIL stat_clr got=%0d exp=0", bus.stall_count); end
  endtask

  task automatic test_redirect();
    bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_rd_addr = 4'd5;
    bus.id_rs_addr = 4'd5; bus.id_uses_rs = 1; bus.ex_redirect = 1;
    #1;
    total++; if (ctl() !== C_REDIR) begin bad++; $display("FAIL redir_lu got=%b exp=%b", ctl(), C_REDIR); end
    step();
    idle();
    #1;
    total++; if (bus.stall_count !== 16'd0) begin bad++; $display("FAIL redir_cnt got=%0d exp=0", bus.stall_count); end
  endtask

  task automatic test_mem_wait();
    bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      bus.ex_redirect = (i == 2);
      #1;
      total++; if (ctl() !== C_MWAIT) begin bad++; $display("FAIL mwait_%0d got=%b exp=%b", i, ctl(), C_MWAIT); end
      step();
    end
    bus.ex_redirect = 0;
    bus.mem_ready = 1;
    #1;
    total++; if (ctl() !== C_NORM) begin bad++; $display("FAIL mwait_ready got=%b exp=%b", ctl(), C_NORM); end
    step();
    idle();
    #1;
    total++; if (bus.stall_count !== 16'd4) begin bad++; $display("FAIL mwait_cnt got=%0d exp=4", bus.stall_count); end
    total++; if (ctl() !== C_NORM || bus.halted !== 1'b0) begin bad++; $display("FAIL mwait_back got=%b/%b exp=%b/0", ctl(), bus.halted, C_NORM); end
  endtask

  task automatic test_timeout();
    bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 0; i < 7; i++) step();
    total++; if (bus.halted !== 1'b0 || bus.mem_err !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b%b exp=00", bus.halted, bus.mem_err); end
    step();
    total++; if (bus.halted !== 1'b1 || bus.mem_err !== 1'b1) begin bad++; $display("FAIL tmo_hit got=%b%b exp=11", bus.halted, bus.mem_err); end
    total++; if (ctl() !== C_HALT) begin bad++; $display("FAIL tmo_ctl got=%b exp=%b", ctl(), C_HALT); end
    idle();
    bus.resume = 1;
    #1;
    total++; if (ctl() !== C_HALT) begin bad++; $display("FAIL tmo_resume_ctl got=%b exp=%b", ctl(), C_HALT); end
    step();
    bus.resume = 0;
    step();
    total++; if (bus.halted !== 1'b1 || bus.mem_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b%b exp=11", bus.halted, bus.mem_err); end
    total++; if (bus.stall_count !== 16'd12) begin bad++; $display("FAIL tmo_cnt got=%0d exp=12", bus.stall_count); end
    rst = 0;
    step();
    rst = 1;
    #1;
    total++; if (bus.halted !== 1'b0 || bus.mem_err !== 1'b0 || bus.stall_count !== 16'd0) begin
      bad++; $display("FAIL tmo_rst got=%b%b/%0d exp=00/0", bus.halted, bus.mem_err, bus.stall_count);
    end
    total++; if (ctl() !== C_NORM) begin bad++; $display("FAIL tmo_rst_ctl got=%b exp=%b", ctl(), C_NORM); end
  endtask

  task automatic test_halt_resume();
    bus.id_halt = 1;
    #1;
    total++; if (ctl() !== C_STALL) begin bad++; $display("FAIL halt_detect got=%b exp=%b", ctl(), C_STALL); end
    step();
    for (int i = 0; i < 3; i++) begin
      total++; if (ctl() !== C_STALL || bus.halted !== 1'b0) begin bad++; $display("FAIL drain_%0d got=%b/%b exp=%b/0", i, ctl(), bus.halted, C_STALL); end
      step();
    end
    total++; if (bus.halted !== 1'b1 || ctl() !== C_HALT) begin bad++; $display("FAIL halted got=%b/%b exp=1/%b", bus.halted, ctl(), C_HALT); end
    total++; if (bus.stall_count !== 16'd4) begin bad++; $display("FAIL halt_cnt got=%0d exp=4", bus.stall_count); end
    step();
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_hold got=%b exp=1", bus.halted); end
    bus.resume = 1;
    #1;
    total++; if (ctl() !== C_RESUME) begin bad++; $display("FAIL resume_ctl got=%b exp=%b", ctl(), C_RESUME); end
    step();
    idle();
    #1;
    total++; if (bus.halted !== 1'b0 || ctl() !== C_NORM) begin bad++; $display("FAIL resume_run got=%b/%b exp=0/%b", bus.halted, ctl(), C_NORM); end
    total++; if (bus.stall_count !== 16'd4) begin bad++; $display("FAIL resume_cnt got=%0d exp=4", bus.stall_count); end
  endtask

  task automatic test_drain_redirect();
    bus.id_halt = 1;
    step();
    #1;
    total++; if (ctl() !== C_STALL) begin bad++; $display("FAIL dr_first got=%b exp=%b", ctl(), C_STALL); end
    step();
    bus.id_halt = 0; bus.ex_redirect = 1;
    #1;
    total++; if (ctl() !== C_REDIR) begin bad++; $display("FAIL dr_redir got=%b exp=%b", ctl(), C_REDIR); end
    step();
    idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (ctl() !== C_NORM || bus.halted !== 1'b0) begin bad++; $display("FAIL dr_run_%0d got=%b/%b exp=%b/0", i, ctl(), bus.halted, C_NORM); end
      step();
    end
  endtask

  initial begin
    idle();
    rst = 0;
    step();
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_halt_resume();
    test_drain_redirect();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
